// File: rtl/o_delay_tap_ctrl_pkg.sv
// rtl/o_delay_tap_ctrl_pkg.sv - shared widths, limits and FSM state type for o_delay_tap_ctrl
package o_delay_tap_ctrl_pkg;

  localparam int TAP_W        = 6;
  localparam int TAP_MAX      = 63;
  localparam int STEP_GAP_MAX = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STEP,
    ST_GAP,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/o_delay_step_pulser.sv
// rtl/o_delay_step_pulser.sv - times the idle gap that follows each load/adjust pulse
// start_i is high during the pulse cycle; gap_done_o flags the last of STEP_GAP gap cycles.
module o_delay_step_pulser
  import o_delay_tap_ctrl_pkg::*;
#(
  parameter int STEP_GAP = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  output logic gap_done_o
);

  logic [3:0] gap_cnt_q;
  logic [3:0] gap_cnt_d;

  always_comb begin
    gap_cnt_d = gap_cnt_q;
    if (start_i) begin
      gap_cnt_d = 4'(STEP_GAP);
    end else if (gap_cnt_q != 4'd0) begin
      gap_cnt_d = gap_cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gap_cnt_q <= 4'd0;
    end else begin
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign gap_done_o = (gap_cnt_q == 4'd1);

endmodule

// File: rtl/o_delay_tap_ctrl.sv
// rtl/o_delay_tap_ctrl.sv - sequences load/adjust pulses to an output delay to reach a target tap
// Optional stall detection: define O_DELAY_TAP_CTRL_STALL_DET_EN.
module o_delay_tap_ctrl
  import o_delay_tap_ctrl_pkg::*;
#(
  parameter int STEP_GAP = 3
) (
  input  logic             CLK_IN,
  input  logic             RST,
  input  logic [TAP_W-1:0] TARGET_TAP,
  input  logic             TARGET_VALID,
  output logic             TARGET_READY,
  input  logic             LOAD_REQ,
  input  logic [TAP_W-1:0] DLY_TAP_VALUE,
  output logic             DLY_LOAD,
  output logic             DLY_ADJ,
  output logic             DLY_INCDEC,
  output logic             BUSY,
  output logic             DONE,
  output logic             STALL
);

  if (STEP_GAP < 2 || STEP_GAP > STEP_GAP_MAX) begin : g_bad_step_gap
    $error("%m: STEP_GAP=%0d outside legal range 2..%0d", STEP_GAP, STEP_GAP_MAX);
  end

  state_t           state_q;
  logic             dly_load_q;
  logic             dly_adj_q;
  logic             dir_q;
  logic             busy_q;
  logic             done_q;
  logic             is_load_q;
  logic [TAP_W-1:0] remaining_q;
  logic [TAP_W-1:0] tap_diff;
  logic             tap_up;
  logic             gap_done;
  logic             step_abort;

  assign tap_up   = (TARGET_TAP > DLY_TAP_VALUE);
  assign tap_diff = tap_up ? (TARGET_TAP - DLY_TAP_VALUE) : (DLY_TAP_VALUE - TARGET_TAP);

  o_delay_step_pulser #(
    .STEP_GAP(STEP_GAP)
  ) u_pulser (
    .clk_i      (CLK_IN),
    .rst_i      (RST),
    .start_i    (dly_adj_q | dly_load_q),
    .gap_done_o (gap_done)
  );

`ifdef O_DELAY_TAP_CTRL_STALL_DET_EN
  // Shadow follows the expected tap; a feedback disagreement at step end means the delay stalled.
  logic             accept;
  logic             step_end;
  logic             mismatch;
  logic             stall_q;
  logic [TAP_W-1:0] shadow_q;
  logic [TAP_W-1:0] shadow_d;

  assign accept     = (state_q == ST_IDLE) && !LOAD_REQ && TARGET_VALID;
  assign step_end   = (state_q == ST_GAP) && gap_done && !is_load_q;
  assign shadow_d   = dir_q ? (shadow_q + 6'd1) : (shadow_q - 6'd1);
  assign mismatch   = (DLY_TAP_VALUE != shadow_d);
  assign step_abort = step_end && mismatch;

  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      shadow_q <= '0;
      stall_q  <= 1'b0;
    end else if (accept) begin
      shadow_q <= DLY_TAP_VALUE;
      stall_q  <= 1'b0;
    end else if (step_end) begin
      shadow_q <= shadow_d;
      if (mismatch) begin
        stall_q <= 1'b1;
      end
    end
  end

  assign STALL = stall_q;
`else
  assign step_abort = 1'b0;
  assign STALL      = 1'b0;
`endif

  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      dly_load_q  <= 1'b0;
      dly_adj_q   <= 1'b0;
      dir_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      is_load_q   <= 1'b0;
      remaining_q <= '0;
    end else begin
      dly_load_q <= 1'b0;
      dly_adj_q  <= 1'b0;
      done_q     <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (LOAD_REQ) begin
            state_q    <= ST_LOAD;
            dly_load_q <= 1'b1;
            busy_q     <= 1'b1;
            is_load_q  <= 1'b1;
          end else if (TARGET_VALID) begin
            dir_q       <= tap_up;
            remaining_q <= tap_diff;
            is_load_q   <= 1'b0;
            busy_q      <= 1'b1;
            if (tap_diff != '0) begin
              state_q   <= ST_STEP;
              dly_adj_q <= 1'b1;
            end else begin
              state_q <= ST_FINISH;
              done_q  <= 1'b1;
            end
          end
        end
        ST_LOAD, ST_STEP: state_q <= ST_GAP;
        ST_GAP: begin
          if (gap_done) begin
            if (!is_load_q) begin
              remaining_q <= remaining_q - 6'd1;
            end
            if (is_load_q || step_abort || remaining_q == 6'd1) begin
              state_q <= ST_FINISH;
              done_q  <= 1'b1;
            end else begin
              state_q   <= ST_STEP;
              dly_adj_q <= 1'b1;
            end
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign TARGET_READY = (state_q == ST_IDLE) && !LOAD_REQ && !RST;
  assign DLY_LOAD     = dly_load_q;
  assign DLY_ADJ      = dly_adj_q;
  assign DLY_INCDEC   = dir_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;

endmodule

// File: tb/tb_o_delay_tap_ctrl.sv
// tb/tb_o_delay_tap_ctrl.sv - self-checking bench for o_delay_tap_ctrl with a behavioural delay model
module tb_o_delay_tap_ctrl;

  localparam int G        = 3;
  localparam int BUDGET   = 400;
  localparam int LOAD_DEF = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] target_tap;
  logic       target_valid;
  logic       target_ready;
  logic       load_req;
  logic [5:0] fb;
  logic       dly_load, dly_adj, dly_incdec, busy, done, stall;

  int total = 0;
  int bad   = 0;

  // Delay model: a control pulse sampled at one edge changes the tap at the following edge.
  logic [5:0] mtap = 6'd0;
  logic       adj_d1 = 1'b0, inc_d1 = 1'b0, ld_d1 = 1'b0;
  logic       set_tap_en = 1'b0;
  logic [5:0] set_tap_val = 6'd0;
  logic       stuck = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (set_tap_en) mtap <= set_tap_val;
    else if (ld_d1) mtap <= 6'(LOAD_DEF);
    else if (adj_d1) mtap <= inc_d1 ? mtap + 6'd1 : mtap - 6'd1;
    adj_d1 <= dly_adj;
    inc_d1 <= dly_incdec;
    ld_d1  <= dly_load;
  end

  assign fb = stuck ? 6'd10 : mtap;

  o_delay_tap_ctrl #(.STEP_GAP(G)) dut (
    .CLK_IN        (clk),
    .RST           (rst),
    .TARGET_TAP    (target_tap),
    .TARGET_VALID  (target_valid),
    .TARGET_READY  (target_ready),
    .LOAD_REQ      (load_req),
    .DLY_TAP_VALUE (fb),
    .DLY_LOAD      (dly_load),
    .DLY_ADJ       (dly_adj),
    .DLY_INCDEC    (dly_incdec),
    .BUSY          (busy),
    .DONE          (done),
    .STALL         (stall)
  );

  typedef struct {
    int st;
    int tg;
    int exp_done;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tap(input int v);
    set_tap_en  = 1'b1;
    set_tap_val = 6'(v);
    tick();
    set_tap_en = 1'b0;
    tick();
  endtask

  task automatic run_req(input int st, input int tg, input int exp_done);
    int n, cyc, pulses, sched_bad, dir_bad, busy_bad, load_seen, done_cyc;
    bit dir;
    n = (tg > st) ? tg - st : st - tg;
    dir = (tg > st);
    pulses = 0; sched_bad = 0; dir_bad = 0; busy_bad = 0; load_seen = 0; done_cyc = -1;
    set_tap(st);
    check("ready_before_accept", int'(target_ready), 1);
    target_tap   = 6'(tg);
    target_valid = 1'b1;
    tick();
    target_valid = 1'b0;
    cyc = 1;
    while (cyc <= BUDGET && done_cyc < 0) begin
      if (dly_adj) begin
        pulses++;
        if ((cyc - 1) % (G + 1) != 0) sched_bad++;
      end
      if (dly_incdec !== dir) dir_bad++;
      if (!busy) busy_bad++;
      if (dly_load) load_seen++;
      if (done) done_cyc = cyc;
      else begin
        tick();
        cyc++;
      end
    end
    check($sformatf("done_cycle %0d->%0d", st, tg), done_cyc, exp_done);
    check($sformatf("pulse_count %0d->%0d", st, tg), pulses, n);
    check("pulse_schedule", sched_bad, 0);
    check("incdec_held", dir_bad, 0);
    check("busy_during_op", busy_bad, 0);
    check("no_load_pulse", load_seen, 0);
    check($sformatf("final_tap %0d->%0d", st, tg), int'(fb), tg);
    check("stall_clear", int'(stall), 0);
    tick();
    check("ready_after_done", int'(target_ready), 1);
    check("idle_after_done", int'({busy, done}), 0);
  endtask

  initial begin
    int st, tg, n, cyc, adj_cnt, load_cnt, done_cyc;

    vecs[0] = '{st: 0,  tg: 5,  exp_done: 21};
    vecs[1] = '{st: 40, tg: 37, exp_done: 13};
    vecs[2] = '{st: 22, tg: 22, exp_done: 1};
    vecs[3] = '{st: 63, tg: 0,  exp_done: 253};
    vecs[4] = '{st: 0,  tg: 63, exp_done: 253};
    vecs[5] = '{st: 10, tg: 11, exp_done: 5};

    rst = 1'b1; target_tap = 6'd0; target_valid = 1'b0; load_req = 1'b0;
    repeat (3) tick();
    check("reset_outputs", int'({dly_load, dly_adj, dly_incdec, busy, done, stall}), 0);
    check("reset_ready", int'(target_ready), 0);
    rst = 1'b0;
    tick();
    check("ready_after_reset", int'(target_ready), 1);
    load_req = 1'b1;
    #1;
    check("ready_masked_by_load_req", int'(target_ready), 0);
    load_req = 1'b0;
    #1;

    foreach (vecs[i]) run_req(vecs[i].st, vecs[i].tg, vecs[i].exp_done);

    for (int k = 0; k < 16; k++) begin
      st = int'($urandom_range(0, 63));
      tg = (k % 5 == 0) ? st : int'($urandom_range(0, 63));
      n  = (tg > st) ? tg - st : st - tg;
      run_req(st, tg, 1 + n * (G + 1));
    end

    // LOAD_REQ beats a simultaneous request; requests during the load are ignored.
    set_tap(30);
    load_req = 1'b1; target_valid = 1'b1; target_tap = 6'd50;
    tick();
    load_req = 1'b0; target_valid = 1'b0;
    cyc = 1; adj_cnt = 0; load_cnt = 0; done_cyc = -1;
    while (cyc <= BUDGET && done_cyc < 0) begin
      if (cyc == 1) check("load_pulse_cycle1", int'(dly_load), 1);
      if (dly_load) load_cnt++;
      if (dly_adj) adj_cnt++;
      if (done) done_cyc = cyc;
      else begin
        if (cyc == 2) begin load_req = 1'b1; target_valid = 1'b1; end
        tick();
        load_req = 1'b0; target_valid = 1'b0;
        cyc++;
      end
    end
    check("load_done_cycle", done_cyc, 2 + G);
    check("load_pulse_count", load_cnt, 1);
    check("load_no_adj", adj_cnt, 0);
    tick();
    check("load_ready_after", int'(target_ready), 1);
    check("load_tap_default", int'(fb), LOAD_DEF);

    // Reset in the gap of step 2 of 4.
    set_tap(0);
    target_tap = 6'd4; target_valid = 1'b1;
    tick();
    target_valid = 1'b0;
    repeat (5) tick();
    check("mid_gap_state", int'({dly_adj, busy}), 1);
    rst = 1'b1;
    tick();
    check("abort_outputs", int'({dly_load, dly_adj, dly_incdec, busy, done, stall}), 0);
    check("abort_ready", int'(target_ready), 0);
    rst = 1'b0;
    adj_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (dly_adj || dly_load) adj_cnt++;
    end
    check("abort_no_pulses", adj_cnt, 0);
    check("abort_ready_after", int'(target_ready), 1);

`ifdef O_DELAY_TAP_CTRL_STALL_DET_EN
    set_tap(10);
    stuck = 1'b1;
    target_tap = 6'd12; target_valid = 1'b1;
    tick();
    target_valid = 1'b0;
    cyc = 1; adj_cnt = 0; done_cyc = -1;
    while (cyc <= BUDGET && done_cyc < 0) begin
      if (dly_adj) adj_cnt++;
      if (done) done_cyc = cyc;
      else begin tick(); cyc++; end
    end
    check("stall_done_cycle", done_cyc, 5);
    check("stall_flag", int'(stall), 1);
    check("stall_one_pulse", adj_cnt, 1);
    repeat (3) tick();
    check("stall_sticky", int'(stall), 1);
    stuck = 1'b0;
    run_req(20, 23, 1 + 3 * (G + 1));
`else
    check("stall_tied_low", int'(stall), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
